// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory answers with a one-cycle ack.
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Program-counter / instruction-fetch stage with IF/ID pipeline register and delay-slot redirect.
// Define FETCH_ALIGN_CHK_EN to turn misaligned PCs into fetch-address exceptions.
module pc_fetch_stage (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    pc_fetch_stage_if.master       imem,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc,
    output logic                   if_id_valid,
    output logic                   if_id_exc
);

`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        valid_q, valid_d;
    logic        exc_q, exc_d;

    logic        misal;
    logic [31:0] seq_pc;
    logic [31:0] nxt_pc;

    assign misal  = ALIGN_CHK && (pc_q[1:0] != 2'b00);
    assign seq_pc = pc_q + 32'd4;
    // A pending redirect outranks the sequential successor.
    assign nxt_pc = pend_q ? pend_pc_q : seq_pc;

    assign imem.imem_req  = (state_q == REQ) && !misal;
    assign imem.imem_addr = ALIGN_CHK ? pc_q : {pc_q[31:2], 2'b00};

    assign if_id_instr = instr_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_valid = valid_q;
    assign if_id_exc   = ALIGN_CHK ? exc_q : 1'b0;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        valid_d      = valid_q;
        exc_d        = exc_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (misal) begin
                    // No fetch issued; keep reporting the fault until ID redirects.
                    if (!stall) begin
                        instr_d = 32'h0;
                        id_pc_d = pc_q;
                        valid_d = 1'b1;
                        exc_d   = 1'b1;
                        if (redirect) begin
                            pc_d = redirect_pc;
                        end
                    end
                end else if (imem.imem_ack) begin
                    pend_d = 1'b0;
                    if (!stall) begin
                        instr_d = imem.imem_rdata;
                        id_pc_d = pc_q;
                        valid_d = 1'b1;
                        exc_d   = 1'b0;
                        pc_d    = redirect ? redirect_pc : nxt_pc;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = pc_q;
                        pc_d         = nxt_pc;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    exc_d   = 1'b0;
                    // Address must stay stable while the request is open.
                    if (redirect) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    instr_d = hold_instr_q;
                    id_pc_d = hold_pc_q;
                    valid_d = 1'b1;
                    exc_d   = 1'b0;
                    state_d = REQ;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
            instr_q      <= 32'h0;
            id_pc_q      <= 32'h0;
            valid_q      <= 1'b0;
            exc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            valid_q      <= valid_d;
            exc_q        <= exc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed testbench for pc_fetch_stage: sequential fetch, redirects, stalls,
// withheld acks, reset during a request and the address-alignment option.
module tb_pc_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        if_id_exc;

    int n_cmp;
    int n_bad;

    pc_fetch_stage_if imem_bus ();

    pc_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .if_id_exc   (if_id_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory answers with data derived from the requested address.
    task automatic drive(input bit a, input bit s, input bit r,
                         input logic [31:0] rp);
        imem_bus.imem_ack   = a;
        imem_bus.imem_rdata = a ? instr_of(imem_bus.imem_addr) : 32'hDEAD_BEEF;
        stall               = s;
        redirect            = r;
        redirect_pc         = rp;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_req: got %b want 0", imem_bus.imem_req);
        end
        n_cmp++;
        if (imem_bus.imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL rst_addr: got %h want 00003000", imem_bus.imem_addr);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_exc !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags: got v=%b e=%b want 0 0", if_id_valid, if_id_exc);
        end
        n_cmp++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_ifid: got pc=%h in=%h want 0 0", if_id_pc, if_id_instr);
        end
        cyc();
        reset = 1'b0;
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_req: got %b want 0", imem_bus.imem_req);
        end
        cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL first_req: got r=%b a=%h want 1 00003000",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        cyc();
        for (int i = 0; i < 4; i++) begin
            exp = 32'h3000 + 32'(4 * i);
            drive(1, 0, 0, 32'h0);
            cyc();
            n_cmp++;
            if (if_id_valid !== 1'b1 || if_id_pc !== exp ||
                if_id_instr !== instr_of(exp)) begin
                n_bad++;
                $display("FAIL seq_%0d: got v=%b pc=%h in=%h want 1 %h %h",
                         i, if_id_valid, if_id_pc, if_id_instr, exp, instr_of(exp));
            end
            n_cmp++;
            if (imem_bus.imem_addr !== exp + 32'd4) begin
                n_bad++;
                $display("FAIL seq_addr_%0d: got %h want %h", i,
                         imem_bus.imem_addr, exp + 32'd4);
            end
        end
        drive(0, 0, 0, 32'h0);
    endtask

    task automatic test_redirect();
        do_reset();
        cyc();
        drive(1, 0, 0, 32'h0);
        cyc();
        drive(1, 0, 0, 32'h0);
        cyc();
        drive(0, 0, 1, 32'h4000);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b0 || imem_bus.imem_addr !== 32'h3008 ||
            imem_bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL redir_wait1: got v=%b a=%h r=%b want 0 00003008 1",
                     if_id_valid, imem_bus.imem_addr, imem_bus.imem_req);
        end
        drive(0, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (imem_bus.imem_addr !== 32'h3008) begin
            n_bad++;
            $display("FAIL redir_wait2: got %h want 00003008", imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3008 ||
            imem_bus.imem_addr !== 32'h4000) begin
            n_bad++;
            $display("FAIL redir_slot: got v=%b pc=%h a=%h want 1 00003008 00004000",
                     if_id_valid, if_id_pc, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h4000 || if_id_instr !== instr_of(32'h4000) ||
            imem_bus.imem_addr !== 32'h4004) begin
            n_bad++;
            $display("FAIL redir_tgt: got pc=%h in=%h a=%h want 00004000 %h 00004004",
                     if_id_pc, if_id_instr, imem_bus.imem_addr, instr_of(32'h4000));
        end
        drive(0, 0, 1, 32'h5000);
        cyc();
        drive(0, 0, 1, 32'h6000);
        cyc();
        n_cmp++;
        if (imem_bus.imem_addr !== 32'h4004) begin
            n_bad++;
            $display("FAIL redir_stable: got %h want 00004004", imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h4004 || imem_bus.imem_addr !== 32'h6000) begin
            n_bad++;
            $display("FAIL redir_replace: got pc=%h a=%h want 00004004 00006000",
                     if_id_pc, imem_bus.imem_addr);
        end
        drive(1, 0, 1, 32'hFFFF_FFFC);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h6000 || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL redir_same: got pc=%h a=%h want 00006000 fffffffc",
                     if_id_pc, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'hFFFF_FFFC || imem_bus.imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap: got pc=%h a=%h want fffffffc 00000000",
                     if_id_pc, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h0 || if_id_instr !== instr_of(32'h0) ||
            imem_bus.imem_addr !== 32'h4) begin
            n_bad++;
            $display("FAIL wrap_next: got pc=%h in=%h a=%h want 0 %h 4",
                     if_id_pc, if_id_instr, imem_bus.imem_addr, instr_of(32'h0));
        end
        drive(0, 0, 0, 32'h0);
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        drive(1, 0, 0, 32'h0);
        cyc();
        drive(1, 1, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if (imem_bus.imem_req !== 1'b0 || if_id_pc !== 32'h3000 ||
                if_id_valid !== 1'b1 || if_id_instr !== instr_of(32'h3000)) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got r=%b pc=%h v=%b want 0 00003000 1",
                         k, imem_bus.imem_req, if_id_pc, if_id_valid);
            end
            drive(0, k < 2, 0, 32'h0);
        end
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h3004 || if_id_instr !== instr_of(32'h3004) ||
            if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got pc=%h in=%h v=%b want 00003004 %h 1",
                     if_id_pc, if_id_instr, if_id_valid, instr_of(32'h3004));
        end
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3008) begin
            n_bad++;
            $display("FAIL stall_next: got r=%b a=%h want 1 00003008",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h3008 || imem_bus.imem_addr !== 32'h300C) begin
            n_bad++;
            $display("FAIL stall_3008: got pc=%h a=%h want 00003008 0000300c",
                     if_id_pc, imem_bus.imem_addr);
        end
        drive(1, 1, 0, 32'h0);
        cyc();
        drive(0, 0, 1, 32'h8000);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h300C || imem_bus.imem_addr !== 32'h8000 ||
            imem_bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_redir: got pc=%h a=%h r=%b want 0000300c 00008000 1",
                     if_id_pc, imem_bus.imem_addr, imem_bus.imem_req);
        end
        drive(0, 1, 1, 32'h9000);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h300C || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_noack: got pc=%h v=%b want 0000300c 1",
                     if_id_pc, if_id_valid);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h8000 || imem_bus.imem_addr !== 32'h8004) begin
            n_bad++;
            $display("FAIL stall_redir_ign: got pc=%h a=%h want 00008000 00008004",
                     if_id_pc, imem_bus.imem_addr);
        end
        drive(0, 0, 0, 32'h0);
    endtask

    task automatic test_ack_withheld();
        do_reset();
        cyc();
        drive(1, 0, 0, 32'h0);
        cyc();
        drive(0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_cmp++;
            if (if_id_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 ||
                imem_bus.imem_addr !== 32'h3004) begin
                n_bad++;
                $display("FAIL wait_%0d: got v=%b r=%b a=%h want 0 1 00003004",
                         k, if_id_valid, imem_bus.imem_req, imem_bus.imem_addr);
            end
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3004) begin
            n_bad++;
            $display("FAIL wait_done: got v=%b pc=%h want 1 00003004",
                     if_id_valid, if_id_pc);
        end
        drive(0, 0, 0, 32'h0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        drive(1, 0, 0, 32'h0);
        cyc();
        drive(0, 0, 0, 32'h0);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
            imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL mid_rst: got v=%b pc=%h r=%b a=%h want 0 0 0 00003000",
                     if_id_valid, if_id_pc, imem_bus.imem_req, imem_bus.imem_addr);
        end
        cyc();
        reset = 1'b0;
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 ||
            imem_bus.imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL stray_ack: got v=%b r=%b a=%h want 0 1 00003000",
                     if_id_valid, imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h3000 ||
            imem_bus.imem_addr !== 32'h3004) begin
            n_bad++;
            $display("FAIL mid_restart: got v=%b pc=%h a=%h want 1 00003000 00003004",
                     if_id_valid, if_id_pc, imem_bus.imem_addr);
        end
        drive(0, 0, 0, 32'h0);
    endtask

    task automatic test_align();
        do_reset();
        cyc();
        drive(1, 0, 1, 32'h4002);
        cyc();
`ifdef FETCH_ALIGN_CHK_EN
        n_cmp++;
        if (if_id_pc !== 32'h3000 || imem_bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL align_noreq: got pc=%h r=%b want 00003000 0",
                     if_id_pc, imem_bus.imem_req);
        end
        drive(0, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_exc !== 1'b1 || if_id_instr !== 32'h0 ||
            if_id_pc !== 32'h4002 || imem_bus.imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL align_exc: got v=%b e=%b in=%h pc=%h r=%b want 1 1 0 00004002 0",
                     if_id_valid, if_id_exc, if_id_instr, if_id_pc, imem_bus.imem_req);
        end
        drive(0, 0, 1, 32'h5000);
        cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h5000) begin
            n_bad++;
            $display("FAIL align_redir: got r=%b a=%h want 1 00005000",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h5000 || if_id_exc !== 1'b0) begin
            n_bad++;
            $display("FAIL align_recover: got pc=%h e=%b want 00005000 0",
                     if_id_pc, if_id_exc);
        end
`else
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4000 ||
            if_id_exc !== 1'b0) begin
            n_bad++;
            $display("FAIL align_force: got r=%b a=%h e=%b want 1 00004000 0",
                     imem_bus.imem_req, imem_bus.imem_addr, if_id_exc);
        end
        drive(1, 0, 0, 32'h0);
        cyc();
        n_cmp++;
        if (if_id_pc !== 32'h4002 || if_id_instr !== instr_of(32'h4000) ||
            if_id_exc !== 1'b0 || imem_bus.imem_addr !== 32'h4004) begin
            n_bad++;
            $display("FAIL align_next: got pc=%h in=%h e=%b a=%h want 00004002 %h 0 00004004",
                     if_id_pc, if_id_instr, if_id_exc, imem_bus.imem_addr,
                     instr_of(32'h4000));
        end
`endif
        drive(0, 0, 0, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        drive(0, 0, 0, 32'h0);
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_ack_withheld();
        test_reset_mid();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 stall  in  1  ID not accepting; IF/ID outputs shall hold.
REQ-004 redirect  in  1  ID holds taken branch/jump; sampled only when stall=0.
REQ-005 redirect_pc  in  32  target computed by next-PC logic, valid with redirect.
REQ-006 imem_req  out  1  fetch request, held until imem_ack.
REQ-007 imem_addr  out  32  word address of request, stable while imem_req=1.
REQ-008 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid same cycle.
REQ-009 imem_rdata  in  32  fetched instruction.
REQ-010 if_id_instr  out  32  instruction to ID.
REQ-011 if_id_pc  out  32  PC of if_id_instr.
REQ-012 if_id_valid  out  1  1 = real instruction, 0 = bubble.
REQ-013 if_id_exc  out  1  fetch-address exception flag (see Configuration).

Function
REQ-014 FSM states: IDLE, REQ, HOLD; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-015 REQ: imem_req=1, imem_addr=pc; IDLE/HOLD: imem_req=0.
REQ-016 REQ, ack=1, stall=0: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=next; stay REQ.
REQ-017 REQ, ack=1, stall=1: instr/pc into hold buffer, pc<=next, go HOLD; IF/ID unchanged.
REQ-018 HOLD, stall=0: hold buffer to IF/ID with valid=1, go REQ next cycle.
REQ-019 REQ, ack=0, stall=0: if_id_valid<=0 (bubble); instr/pc regs may retain old values.
REQ-020 stall=1 in any state: IF/ID registers unchanged.
REQ-021 next = redirect target if one is pending or sampled this cycle, else pc+4 (mod 2^32, wraps 0xFFFFFFFC->0).
REQ-022 Delay slot: the fetch in flight when redirect is sampled completes and is delivered; redirect never flushes it.
REQ-023 redirect sampled in REQ with ack=0: latch redirect_pc into redir_pend, set pend flag; consumed (pc<=redir_pend, flag cleared) on next ack.
REQ-024 redirect sampled in REQ with ack=1 same cycle: pc<=redirect_pc directly; no pend.
REQ-025 redirect sampled in HOLD (stall=0 exit cycle): pc<=redirect_pc, overriding pc+4 already applied.
REQ-026 Second redirect while pend set: newer target replaces older.
REQ-027 imem_addr shall not change while imem_req=1 and ack=0, even if redirect arrives.
REQ-028 Fetch latency: ack in cycle N -> if_id_valid=1 from cycle N+1 (stall=0).

Reset
REQ-029 Async assert: pc=0x00003000, state=IDLE, imem_req=0, imem_addr=0x00003000.
REQ-030 Async assert: if_id_instr=0, if_id_pc=0, if_id_valid=0, if_id_exc=0, pend=0, hold buffer=0.
REQ-031 Reset mid-request: outstanding request abandoned; an ack in the cycle reset deasserts is ignored (state IDLE).

Configuration
REQ-032 Macro FETCH_ALIGN_CHK_EN.
REQ-033 Defined: pc[1:0]!=0 in REQ -> no imem_req, deliver if_id_valid=1, if_id_exc=1, if_id_instr=0, if_id_pc=pc; pc held until redirect.
REQ-034 Undefined: imem_addr[1:0] forced 00, if_id_exc tied 0.

Verification
REQ-035 Reset release, ack every cycle, stall=0 -> if_id_pc 0x3000,0x3004,0x3008 on consecutive cycles.
REQ-036 redirect=1 to 0x4000 while 0x3008 in flight, ack 2 cycles later -> 0x3008 delivered, next request addr 0x4000.
REQ-037 stall=1 at ack of 0x3004 for 3 cycles -> IF/ID holds 0x3000, imem_req=0; stall drop -> 0x3004 delivered, then 0x3008 fetched.
REQ-038 ack withheld 4 cycles -> if_id_valid=0 for those cycles, imem_addr constant.
REQ-039 Reset asserted during pending request -> pc=0x3000, if_id_valid=0 immediately, stray ack ignored.
REQ-040 FETCH_ALIGN_CHK_EN, redirect to 0x4002 -> if_id_exc=1, if_id_pc=0x4002, no imem_req at 0x4002.
